trace_flush_controller: RTL and testbench

Upstream feeder for the AXI burst write engine in the kernel tracer. Accepts a stream of trace words, packs them into a ping-pong on-chip data buffer, and whenever a half fills (or a flush is requested) issues a start command to the burst write engine. Each command carries the buffer pointer, the word count and the AXI byte offset into a circular trace region in device memory. The block frees the half only after the engine's done handshake.

---
 rtl/trace_flush_controller.sv | 212 +++++++++++++++++++++
 tb/tb_trace_flush_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_flush_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trace_flush_controller                                                   |
// | Packs trace words into a ping-pong buffer and issues ring-addressed      |
// | burst commands. Optional macro: TRACE_DROP_ON_FULL_EN (drop, not stall). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trace_flush_controller #(
  parameter int                       BUFFER_ADDR_WIDTH = 8,
  parameter int                       BUFFER_DATA_WIDTH = 32,
  parameter int                       AXI_ADDR_WIDTH    = 32,
  parameter int                       AXI_DATA_WIDTH    = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] RING_BASE_ADDR   = '0,
  parameter int                       RING_NUM_WORDS    = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [BUFFER_DATA_WIDTH-1:0] trace_data,
  input  logic                         trace_valid,
  output logic                         trace_ready,
  input  logic                         flush_req,
  output logic                         buf_wr_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] buf_wr_data,
  output logic                         start_valid,
  input  logic                         start_ready,
  output logic [BUFFER_ADDR_WIDTH-1:0] data_ptr,
  output logic [BUFFER_ADDR_WIDTH-1:0] data_size,
  output logic [AXI_ADDR_WIDTH-1:0]    axi_offset,
  input  logic                         done_valid,
  output logic                         done_ready,
  output logic                         ring_wrapped,
  output logic [31:0]                  drop_count,
  output logic                         idle
);

  localparam int                         c_H      = 2 ** (BUFFER_ADDR_WIDTH - 1);
  localparam logic [BUFFER_ADDR_WIDTH-1:0] c_H_W  = c_H[BUFFER_ADDR_WIDTH-1:0];
  localparam logic [31:0]                c_STRIDE = AXI_DATA_WIDTH / 8;
  localparam logic [31:0]                c_RING   = RING_NUM_WORDS;
  localparam int                         c_RPW    = $clog2(RING_NUM_WORDS + 1);

  localparam logic [1:0] c_FREE     = 2'd0;
  localparam logic [1:0] c_FILLING  = 2'd1;
  localparam logic [1:0] c_PENDING  = 2'd2;
  localparam logic [1:0] c_FLUSHING = 2'd3;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_ISSUE     = 2'd1;
  localparam logic [1:0] c_WAIT_DONE = 2'd2;

  logic [1:0][1:0]                   r_half_st;
  logic [1:0][BUFFER_ADDR_WIDTH-1:0] r_half_size;
  logic                              r_fill_half;
  logic                              r_flush_half;
  logic [BUFFER_ADDR_WIDTH-1:0]      r_fill_cnt;
  logic [1:0]                        r_fsm;
  logic                              r_start_valid;
  logic [BUFFER_ADDR_WIDTH-1:0]      r_data_ptr, r_data_size, r_rem_ptr, r_rem_size;
  logic [AXI_ADDR_WIDTH-1:0]         r_axi_offset;
  logic [c_RPW-1:0]                  r_ring_ptr;
  logic                              r_ring_wrapped;
  logic                              r_buf_wr_en;
  logic [BUFFER_ADDR_WIDTH-1:0]      r_buf_wr_addr;
  logic [BUFFER_DATA_WIDTH-1:0]      r_buf_wr_data;

  logic                         w_filling, w_accept, w_commit, w_other, w_fill_half_nx, w_split;
  logic [BUFFER_ADDR_WIDTH-1:0] w_cnt_nx, w_src_ptr, w_src_size, w_cmd_size, w_rem_size, w_rem_ptr;
  logic [31:0]                  w_room, w_ring_sum;
  logic [AXI_ADDR_WIDTH-1:0]    w_axi;
  logic                         w_half0_empty, w_half1_empty;

  assign w_filling = (r_half_st[r_fill_half] == c_FILLING);
  assign w_other   = ~r_fill_half;

`ifdef TRACE_DROP_ON_FULL_EN
  logic        w_drop;
  logic [31:0] r_drop_count;
  assign trace_ready = 1'b1;
  assign w_accept    = trace_valid && w_filling;
  assign w_drop      = trace_valid && !w_filling;
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_drop_count <= '0;
    else if (w_drop && (r_drop_count != 32'hFFFF_FFFF))
      r_drop_count <= r_drop_count + 32'd1;
  end
  assign drop_count = r_drop_count;
`else
  assign trace_ready = w_filling;
  assign w_accept    = trace_valid && w_filling;
  assign drop_count  = '0;
`endif

  // A flush coinciding with the last word of a half is absorbed into one commit.
  assign w_cnt_nx       = r_fill_cnt + {{(BUFFER_ADDR_WIDTH-1){1'b0}}, w_accept};
  assign w_commit       = w_filling && ((w_cnt_nx == c_H_W) || (flush_req && (w_cnt_nx != '0)));
  assign w_fill_half_nx = r_fill_half ^ w_commit;

  // One command builder serves both a fresh half and a split remainder.
  assign w_src_ptr  = (r_fsm == c_IDLE) ? {r_flush_half, {(BUFFER_ADDR_WIDTH-1){1'b0}}} : r_rem_ptr;
  assign w_src_size = (r_fsm == c_IDLE) ? r_half_size[r_flush_half] : r_rem_size;
  assign w_room     = c_RING - 32'(r_ring_ptr);
  assign w_split    = 32'(w_src_size) > w_room;
  assign w_cmd_size = w_split ? BUFFER_ADDR_WIDTH'(w_room) : w_src_size;
  assign w_rem_size = w_src_size - w_cmd_size;
  assign w_rem_ptr  = w_src_ptr + w_cmd_size;
  assign w_axi      = RING_BASE_ADDR + AXI_ADDR_WIDTH'(32'(r_ring_ptr) * c_STRIDE);
  assign w_ring_sum = 32'(r_ring_ptr) + 32'(r_data_size);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_half_st      <= {c_FREE, c_FILLING};
      r_half_size    <= '0;
      r_fill_half    <= 1'b0;
      r_flush_half   <= 1'b0;
      r_fill_cnt     <= '0;
      r_fsm          <= c_IDLE;
      r_start_valid  <= 1'b0;
      r_data_ptr     <= '0;
      r_data_size    <= '0;
      r_rem_ptr      <= '0;
      r_rem_size     <= '0;
      r_axi_offset   <= RING_BASE_ADDR;
      r_ring_ptr     <= '0;
      r_ring_wrapped <= 1'b0;
      r_buf_wr_en    <= 1'b0;
      r_buf_wr_addr  <= '0;
      r_buf_wr_data  <= '0;
    end else begin
      r_buf_wr_en <= w_accept;
      if (w_accept) begin
        r_buf_wr_addr <= {r_fill_half, r_fill_cnt[BUFFER_ADDR_WIDTH-2:0]};
        r_buf_wr_data <= trace_data;
      end

      if (w_commit) begin
        r_half_st[r_fill_half]   <= c_PENDING;
        r_half_size[r_fill_half] <= w_cnt_nx;
        r_fill_cnt               <= '0;
        r_fill_half              <= w_other;
        if (r_half_st[w_other] == c_FREE)
          r_half_st[w_other] <= c_FILLING;
      end else if (w_accept) begin
        r_fill_cnt <= w_cnt_nx;
      end

      case (r_fsm)
        c_IDLE: begin
          if (r_half_st[r_flush_half] == c_PENDING) begin
            r_half_st[r_flush_half] <= c_FLUSHING;
            r_data_ptr   <= w_src_ptr;
            r_data_size  <= w_cmd_size;
            r_axi_offset <= w_axi;
            r_rem_ptr    <= w_rem_ptr;
            r_rem_size   <= w_rem_size;
            r_fsm        <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          // One idle cycle before valid keeps the last buffer write ahead of the engine read.
          if (!r_start_valid) begin
            r_start_valid <= 1'b1;
          end else if (start_ready) begin
            r_start_valid <= 1'b0;
            if (w_ring_sum >= c_RING) begin
              r_ring_ptr     <= '0;
              r_ring_wrapped <= 1'b1;
            end else begin
              r_ring_ptr <= c_RPW'(w_ring_sum);
            end
            r_fsm <= c_WAIT_DONE;
          end
        end
        c_WAIT_DONE: begin
          if (done_valid) begin
            if (r_rem_size != '0) begin
              r_data_ptr   <= w_src_ptr;
              r_data_size  <= w_cmd_size;
              r_axi_offset <= w_axi;
              r_rem_ptr    <= w_rem_ptr;
              r_rem_size   <= w_rem_size;
              r_fsm        <= c_ISSUE;
            end else begin
              // A freed half that fill is waiting on resumes filling immediately.
              r_half_st[r_flush_half] <= (r_flush_half == w_fill_half_nx) ? c_FILLING : c_FREE;
              r_flush_half <= ~r_flush_half;
              r_fsm        <= c_IDLE;
            end
          end
        end
        default: r_fsm <= c_IDLE;
      endcase
    end
  end

  assign w_half0_empty = (r_half_st[0] == c_FREE) || ((r_half_st[0] == c_FILLING) && (r_fill_cnt == '0));
  assign w_half1_empty = (r_half_st[1] == c_FREE) || ((r_half_st[1] == c_FILLING) && (r_fill_cnt == '0));

  assign idle         = (r_fsm == c_IDLE) && w_half0_empty && w_half1_empty;
  assign start_valid  = r_start_valid;
  assign done_ready   = (r_fsm == c_WAIT_DONE);
  assign data_ptr     = r_data_ptr;
  assign data_size    = r_data_size;
  assign axi_offset   = r_axi_offset;
  assign ring_wrapped = r_ring_wrapped;
  assign buf_wr_en    = r_buf_wr_en;
  assign buf_wr_addr  = r_buf_wr_addr;
  assign buf_wr_data  = r_buf_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_trace_flush_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trace_flush_controller                                                |
// | Directed bench: ping-pong fill, flush, stall, ring split, reset.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_trace_flush_controller;

  localparam int RING = 256;
  localparam int NCMD = 13;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] trace_data = '0;
  logic        trace_valid = 1'b0;
  logic        trace_ready;
  logic        flush_req = 1'b0;
  logic        buf_wr_en;
  logic [7:0]  buf_wr_addr;
  logic [31:0] buf_wr_data;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  data_ptr, data_size;
  logic [31:0] axi_offset;
  logic        done_valid;
  logic        done_ready;
  logic        ring_wrapped;
  logic [31:0] drop_count;
  logic        idle;

  always #5 clk = ~clk;

  trace_flush_controller #(
    .BUFFER_ADDR_WIDTH(8),
    .BUFFER_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .RING_BASE_ADDR(32'h0),
    .RING_NUM_WORDS(RING)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .flush_req(flush_req),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .start_valid(start_valid), .start_ready(start_ready),
    .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
    .done_valid(done_valid), .done_ready(done_ready),
    .ring_wrapped(ring_wrapped), .drop_count(drop_count), .idle(idle)
  );

  typedef struct {
    logic [7:0]  ptr;
    logic [7:0]  size;
    logic [31:0] off;
  } cmd_t;

  cmd_t cmds_got[$];
  cmd_t exp_cmds[NCMD];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Engine model: accepts commands at once, answers done one cycle later unless held.
  logic eng_hold = 1'b0;
  bit   eng_busy = 1'b0;
  bit   e_hs_s, e_hs_d, e_rst;
  initial begin
    start_ready = 1'b1;
    done_valid  = 1'b0;
    forever begin
      @(negedge clk);
      e_rst  = !reset_n;
      e_hs_s = reset_n && start_valid && start_ready;
      e_hs_d = reset_n && done_valid && done_ready;
      if (e_hs_s) cmds_got.push_back('{data_ptr, data_size, axi_offset});
      @(posedge clk);
      #1;
      if (e_rst) begin
        eng_busy   = 1'b0;
        done_valid = 1'b0;
      end else begin
        if (e_hs_d) begin
          done_valid = 1'b0;
          eng_busy   = 1'b0;
        end
        if (e_hs_s) eng_busy = 1'b1;
        if (eng_busy && !eng_hold && !done_valid) done_valid = 1'b1;
      end
    end
  end

  logic [31:0] tb_mem [256];
  logic [7:0]  last_wr_addr = '0;
  always @(negedge clk) begin
    if (reset_n && buf_wr_en) begin
      tb_mem[buf_wr_addr] = buf_wr_data;
      last_wr_addr        = buf_wr_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    trace_valid = 1'b0;
    flush_req   = 1'b0;
    eng_hold    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input int budget, output bit ok);
    trace_valid = 1'b1;
    trace_data  = d;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = trace_ready;
      tick();
    end
    trace_valid = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [31:0] base, input string name);
    bit ok;
    int acc = 0;
    for (int i = 0; i < n; i++) begin
      send_word(base + 32'(i), 2000, ok);
      if (!ok) break;
      acc++;
    end
    check(name, 64'(acc), 64'(n));
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (idle) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic check_buf(input string name, input int lo, input int n, input logic [31:0] base);
    bit okb = 1'b1;
    for (int i = 0; i < n; i++)
      if (tb_mem[lo + i] !== base + 32'(i)) okb = 1'b0;
    check(name, 64'(okb), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    int base_n;

    exp_cmds[0]  = '{8'd0,   8'd128, 32'h000};
    exp_cmds[1]  = '{8'd0,   8'd5,   32'h000};
    exp_cmds[2]  = '{8'd128, 8'd1,   32'h014};
    exp_cmds[3]  = '{8'd0,   8'd128, 32'h000};
    exp_cmds[4]  = '{8'd128, 8'd128, 32'h200};
    exp_cmds[5]  = '{8'd0,   8'd1,   32'h000};
    exp_cmds[6]  = '{8'd0,   8'd3,   32'h000};
    exp_cmds[7]  = '{8'd128, 8'd128, 32'h00C};
    exp_cmds[8]  = '{8'd0,   8'd125, 32'h20C};
    exp_cmds[9]  = '{8'd125, 8'd3,   32'h000};
    exp_cmds[10] = '{8'd128, 8'd128, 32'h00C};
    exp_cmds[11] = '{8'd0,   8'd128, 32'h000};
    exp_cmds[12] = '{8'd0,   8'd1,   32'h000};

    // Reset state
    do_reset();
    check("rst_trace_ready",  64'(trace_ready),  64'd1);
    check("rst_buf_wr_en",    64'(buf_wr_en),    64'd0);
    check("rst_buf_wr_addr",  64'(buf_wr_addr),  64'd0);
    check("rst_buf_wr_data",  64'(buf_wr_data),  64'd0);
    check("rst_start_valid",  64'(start_valid),  64'd0);
    check("rst_data_ptr",     64'(data_ptr),     64'd0);
    check("rst_data_size",    64'(data_size),    64'd0);
    check("rst_axi_offset",   64'(axi_offset),   64'd0);
    check("rst_done_ready",   64'(done_ready),   64'd0);
    check("rst_ring_wrapped", 64'(ring_wrapped), 64'd0);
    check("rst_drop_count",   64'(drop_count),   64'd0);
    check("rst_idle",         64'(idle),         64'd1);

    // One full half
    send_burst(128, 32'hA000, "s1_accept");
    wait_idle("s1_idle", 1000);
    check_buf("s1_buffer", 0, 128, 32'hA000);
    check("s1_ring_wrapped", 64'(ring_wrapped), 64'd0);

    // Partial flush, then fill moves to half 1
    do_reset();
    send_burst(5, 32'hB000, "s2_accept");
    pulse_flush();
    send_word(32'hB005, 100, ok);
    check("s2_next_accept", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    check("s2_next_addr", 64'(last_wr_addr), 64'd128);
    check("s2_next_data", 64'(tb_mem[128]), 64'hB005);
    tick();
    pulse_flush();
    wait_idle("s2_idle", 1000);

    // Stalled engine: both halves fill, then backpressure
    do_reset();
    base_n   = cmds_got.size();
    eng_hold = 1'b1;
    send_burst(256, 32'hC000, "s3_accept");
    send_word(32'hC100, 20, ok);
    check("s3_backpressure", 64'(ok), 64'd0);
    check("s3_trace_ready_low", 64'(trace_ready), 64'd0);
`ifndef TRACE_DROP_ON_FULL_EN
    check("s3_drop_count_tied", 64'(drop_count), 64'd0);
`endif
    repeat (200) tick();
    check("s3_one_cmd_stalled", 64'(cmds_got.size() - base_n), 64'd1);
    eng_hold = 1'b0;
    wait_idle("s3_idle", 2000);
    check_buf("s3_buffer", 0, 256, 32'hC000);
    check("s3_ring_wrapped", 64'(ring_wrapped), 64'd1);
    send_word(32'hC100, 100, ok);
    check("s3_resume_accept", 64'(ok), 64'd1);
    pulse_flush();
    wait_idle("s3_idle2", 1000);

    // Ring split with a 256-word ring
    do_reset();
    send_burst(3, 32'hD000, "s4_accept_a");
    pulse_flush();
    send_burst(128, 32'hD100, "s4_accept_b");
    wait_idle("s4_idle_b", 1000);
    check("s4_no_wrap_yet", 64'(ring_wrapped), 64'd0);
    send_burst(128, 32'hD200, "s4_accept_c");
    wait_idle("s4_idle_c", 1000);
    check("s4_wrapped", 64'(ring_wrapped), 64'd1);
    send_burst(128, 32'hD300, "s4_accept_d");
    wait_idle("s4_idle_d", 1000);
    check_buf("s4_buffer_h0", 0, 128, 32'hD200);
    check_buf("s4_buffer_h1", 128, 128, 32'hD300);

    // Reset while waiting for done
    do_reset();
    eng_hold = 1'b1;
    send_burst(128, 32'hE000, "s5_accept");
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("s5_wait_done", 64'(seen), 64'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n  = 1'b1;
    eng_hold = 1'b0;
    check("s5_start_valid", 64'(start_valid), 64'd0);
    check("s5_done_ready",  64'(done_ready),  64'd0);
    check("s5_idle",        64'(idle),        64'd1);
    check("s5_trace_ready", 64'(trace_ready), 64'd1);
    send_word(32'hE100, 100, ok);
    repeat (2) @(negedge clk);
    check("s5_fill_half0", 64'(last_wr_addr), 64'd0);
    tick();
    pulse_flush();
    wait_idle("s5_idle2", 1000);

    // Command log against the hand-computed table
    check("cmd_count", 64'(cmds_got.size()), 64'(NCMD));
    for (int i = 0; i < NCMD; i++) begin
      if (i < cmds_got.size())
        check($sformatf("cmd%0d", i),
              {16'h0, cmds_got[i].ptr, cmds_got[i].size, cmds_got[i].off},
              {16'h0, exp_cmds[i].ptr, exp_cmds[i].size, exp_cmds[i].off});
    end

`ifdef TRACE_DROP_ON_FULL_EN
    begin
      bit rdy_ok = 1'b1;
      do_reset();
      eng_hold = 1'b1;
      for (int i = 0; i < 300; i++) begin
        trace_valid = 1'b1;
        trace_data  = 32'hF000 + 32'(i);
        @(negedge clk);
        if (!trace_ready) rdy_ok = 1'b0;
        tick();
      end
      trace_valid = 1'b0;
      tick();
      check("drop_count_44", 64'(drop_count), 64'd44);
      check("drop_ready_high", 64'(rdy_ok), 64'd1);
      eng_hold = 1'b0;
      wait_idle("drop_idle", 2000);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
